// File: rtl/fg_pkg.sv
// Shared types and default widths for the function-generator phase path.
package fg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

  localparam int FG_BITWIDTH_PHASE    = 10;
  localparam int FG_BITWIDTH_ACC      = 16;
  localparam int FG_BITWIDTH_PRESCALE = 8;
  // Enable pulses from phase sample to valid rotator output; the CORDIC instance uses the same value.
  localparam int FG_CORDIC_LATENCY    = 8;

endpackage

// File: rtl/fg_prescaler.sv
// Clock-enable prescaler: registered strobe every (prescale+1) cycles while en is high.
module fg_prescaler #(
  parameter int BITWIDTH_PRESCALE = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [BITWIDTH_PRESCALE-1:0] prescale,
  output logic                         clk_en
);

  logic [BITWIDTH_PRESCALE-1:0] count;

  // The >= compare makes a live decrease of prescale below count wrap at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      clk_en <= 1'b0;
    end else if (!en) begin
      count  <= '0;
      clk_en <= 1'b0;
    end else if (count >= prescale) begin
      count  <= '0;
      clk_en <= 1'b1;
    end else begin
      count  <= count + 1'b1;
      clk_en <= 1'b0;
    end
  end

endmodule

// File: rtl/fg_phase_sweep.sv
// Phase accumulator, fixed/sweep FCW control and CORDIC valid tracking.
// Optional build macro FG_SWEEP_REPEAT_EN turns a single sweep into a repeating sawtooth chirp.
module fg_phase_sweep
  import fg_pkg::*;
#(
  parameter int BITWIDTH_PHASE    = FG_BITWIDTH_PHASE,
  parameter int BITWIDTH_ACC      = FG_BITWIDTH_ACC,
  parameter int BITWIDTH_PRESCALE = FG_BITWIDTH_PRESCALE,
  parameter int CORDIC_LATENCY    = FG_CORDIC_LATENCY
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             stop_i,
  input  logic                             sweep_en_i,
  input  logic [BITWIDTH_PRESCALE-1:0]     prescale_i,
  input  logic [BITWIDTH_ACC-1:0]          fcw_start_i,
  input  logic [BITWIDTH_ACC-1:0]          fcw_stop_i,
  input  logic [BITWIDTH_ACC-1:0]          fcw_step_i,
  output logic                             clk_en_o,
  output logic signed [BITWIDTH_PHASE-1:0] phase_o,
  output logic [BITWIDTH_ACC-1:0]          fcw_o,
  output logic                             busy_o,
  output logic                             valid_o,
  output logic                             sweep_done_o
);

  localparam int VW = $clog2(CORDIC_LATENCY + 1);

  state_t                  state, state_nxt;
  logic [BITWIDTH_ACC-1:0] acc, acc_nxt;
  logic [BITWIDTH_ACC-1:0] fcw, fcw_nxt;
  logic [BITWIDTH_ACC:0]   fcw_sum;
  logic [VW-1:0]           vcnt, vcnt_nxt;
  logic                    done_nxt;
  logic                    run_en;

`ifdef FG_SWEEP_REPEAT_EN
  logic [BITWIDTH_ACC-1:0] fcw_first;
  logic                    wrap, wrap_nxt;
`endif

  assign busy_o  = (state != ST_IDLE);
  assign run_en  = busy_o && !stop_i;
  assign fcw_sum = {1'b0, fcw} + {1'b0, fcw_step_i};
  assign phase_o = acc[BITWIDTH_ACC-1 -: BITWIDTH_PHASE];
  assign fcw_o   = fcw;
  assign valid_o = (vcnt == VW'(CORDIC_LATENCY));

  fg_prescaler #(
    .BITWIDTH_PRESCALE(BITWIDTH_PRESCALE)
  ) u_prescaler (
    .clk      (clk_i),
    .rst      (rst_i),
    .en       (run_en),
    .prescale (prescale_i),
    .clk_en   (clk_en_o)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    fcw_nxt   = fcw;
    vcnt_nxt  = vcnt;
    done_nxt  = 1'b0;
`ifdef FG_SWEEP_REPEAT_EN
    wrap_nxt  = wrap;
`endif
    case (state)
      ST_IDLE: begin
        acc_nxt  = '0;
        vcnt_nxt = '0;
        if (start_i && !stop_i) begin
          fcw_nxt   = fcw_start_i;
          state_nxt = sweep_en_i ? ST_SWEEP : ST_RUN;
`ifdef FG_SWEEP_REPEAT_EN
          wrap_nxt  = 1'b0;
`endif
        end
      end
      default: begin
        if (stop_i) begin
          state_nxt = ST_IDLE;
          acc_nxt   = '0;
          vcnt_nxt  = '0;
`ifdef FG_SWEEP_REPEAT_EN
          wrap_nxt  = 1'b0;
`endif
        end else if (clk_en_o) begin
          acc_nxt = acc + fcw;
          if (vcnt != VW'(CORDIC_LATENCY))
            vcnt_nxt = vcnt + VW'(1);
          if (state == ST_SWEEP) begin
`ifdef FG_SWEEP_REPEAT_EN
            // The stop FCW is held for one enable before reloading the start FCW.
            if (wrap) begin
              fcw_nxt  = fcw_first;
              wrap_nxt = 1'b0;
            end else if (fcw_sum >= {1'b0, fcw_stop_i}) begin
              fcw_nxt  = fcw_stop_i;
              done_nxt = 1'b1;
              wrap_nxt = 1'b1;
            end else begin
              fcw_nxt = fcw_sum[BITWIDTH_ACC-1:0];
            end
`else
            if (fcw_sum >= {1'b0, fcw_stop_i}) begin
              fcw_nxt   = fcw_stop_i;
              done_nxt  = 1'b1;
              state_nxt = ST_RUN;
            end else begin
              fcw_nxt = fcw_sum[BITWIDTH_ACC-1:0];
            end
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      acc          <= '0;
      fcw          <= '0;
      vcnt         <= '0;
      sweep_done_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      acc          <= acc_nxt;
      fcw          <= fcw_nxt;
      vcnt         <= vcnt_nxt;
      sweep_done_o <= done_nxt;
    end
  end

`ifdef FG_SWEEP_REPEAT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fcw_first <= '0;
      wrap      <= 1'b0;
    end else begin
      if (state == ST_IDLE && start_i && !stop_i)
        fcw_first <= fcw_start_i;
      wrap <= wrap_nxt;
    end
  end
`endif

endmodule

// File: doc/fg_phase_sweep.md
Name: fg_phase_sweep

Overview:
- Phase-generation stage sitting directly upstream of the CORDIC rotator in the function generator.
- Produces the signed phase word, the shared clock-enable strobe, and a valid flag aligned with the CORDIC output.
- Supports fixed-frequency operation and a linear frequency sweep from a start tuning word up to a stop tuning word.

Parameters:
- BITWIDTH_PHASE, 10, width of phase_o; full scale = 2*pi; top two bits = quadrant.
- BITWIDTH_ACC, 16, width of the phase accumulator and of all frequency tuning words (FCW).
- BITWIDTH_PRESCALE, 8, width of the clock-enable prescaler.
- CORDIC_LATENCY, 8, number of clk_en_o pulses from phase sample to valid CORDIC output.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous, active-high
- start_i  in  1  start pulse; leaves IDLE
- stop_i  in  1  stop pulse; returns to IDLE; has priority over start_i
- sweep_en_i  in  1  sampled on start: 0 = fixed frequency, 1 = sweep
- prescale_i  in  BITWIDTH_PRESCALE  enable period minus 1; read live
- fcw_start_i  in  BITWIDTH_ACC  initial FCW, unsigned; captured on start
- fcw_stop_i  in  BITWIDTH_ACC  sweep end FCW, unsigned; read live
- fcw_step_i  in  BITWIDTH_ACC  FCW increment per enable in SWEEP, unsigned; read live
- clk_en_o  out  1  registered enable strobe driving the CORDIC clk_en_i
- phase_o  out  BITWIDTH_PHASE  signed phase = acc[BITWIDTH_ACC-1 -: BITWIDTH_PHASE]
- fcw_o  out  BITWIDTH_ACC  current FCW
- busy_o  out  1  state != IDLE
- valid_o  out  1  CORDIC output currently valid
- sweep_done_o  out  1  one-cycle pulse when FCW reaches fcw_stop_i

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE; acc = 0; fcw = 0; prescaler count = 0; latency count = 0.
  - All outputs = 0.
- FSM states: IDLE, RUN, SWEEP.
- IDLE:
  - acc, count, clk_en_o and valid_o are held at 0.
  - start_i=1 and stop_i=0: load fcw <= fcw_start_i; go to SWEEP if sweep_en_i=1, else RUN.
- RUN / SWEEP:
  - stop_i=1: go to IDLE on the next edge and clear acc, count, clk_en_o and valid.
  - start_i is ignored while busy.
- Prescaler (active in RUN/SWEEP only):
  - If count >= prescale_i: count <= 0 and clk_en_o <= 1.
  - Else: count++ and clk_en_o <= 0.
  - prescale_i=0 gives clk_en_o=1 every cycle after the first.
  - Lowering prescale_i below count causes an immediate wrap (>= compare).
  - First clk_en_o rises one cycle after leaving IDLE.
- Accumulator:
  - On each edge where clk_en_o=1: acc <= acc + fcw, modulo 2^BITWIDTH_ACC, wrapping silently.
  - The CORDIC therefore samples the pre-update phase_o on the same edge.
  - First sampled phase after start = 0.
- SWEEP FCW update, on each edge where clk_en_o=1:
  - Compute next = fcw + fcw_step_i in BITWIDTH_ACC+1 bits.
  - If next >= fcw_stop_i: fcw <= fcw_stop_i; pulse sweep_done_o for 1 cycle; go to RUN.
  - Otherwise fcw <= next.
  - If fcw_start_i >= fcw_stop_i: completes on the first enable.
  - If fcw_step_i = 0: never completes.
- valid_o:
  - Saturating counter increments on each clk_en_o edge while busy.
  - valid_o = (count == CORDIC_LATENCY).
  - Counter clears in IDLE and on stop.
  - A RUN/SWEEP transition does not clear it.
- Simultaneous start_i and stop_i in IDLE: stay in IDLE.

Optional Feature:
- Macro: FG_SWEEP_REPEAT_EN.
- Defined: on sweep completion, sweep_done_o pulses, fcw reloads the captured fcw_start value, and the state stays SWEEP (sawtooth chirp repeats indefinitely). A dedicated register holds the captured start FCW.
- Undefined: completion goes to RUN holding fcw_stop_i (single sweep), and no start-FCW register exists.

Decomposition:
- Shared package fg_pkg:
  - state enum (IDLE, RUN, SWEEP);
  - default widths (BITWIDTH_PHASE=10, BITWIDTH_ACC=16, BITWIDTH_PRESCALE=8);
  - CORDIC_LATENCY constant, shared with the CORDIC instantiation.
- Sub-module fg_prescaler (counter + registered strobe, enable input = busy).
- Accumulator, FSM and valid tracking stay in the top module.

Test Plan:
- Reset mid-run: assert rst_i asynchronously between clock edges -> all outputs 0 immediately, without waiting for a clock.
- Fixed frequency: prescale_i=0, fcw_start_i=0x0400, sweep_en_i=0, start -> clk_en_o high every cycle from cycle 2. phase_o sequence 0,16,32,...; wraps 496 -> -512 (signed), period 64 enables. valid_o rises on the 8th enable.
- Prescaler: prescale_i=3 -> clk_en_o exactly 1 cycle in 4. phase steps once per pulse. Change to 1 mid-run -> period 2 from the next wrap.
- Sweep: fcw_start_i=0x0100, fcw_step_i=0x0100, fcw_stop_i=0x0480 -> fcw_o 0x0100, 0x0200, 0x0300, 0x0400, then 0x0480 with a sweep_done_o pulse. State RUN; fcw_o stays 0x0480.
- Sweep repeat (FG_SWEEP_REPEAT_EN defined): same stimulus -> after 0x0480, fcw_o = 0x0100. sweep_done_o pulses every 5 enables.
- stop_i and start_i together while in RUN -> IDLE next edge; busy_o=0, valid_o=0, phase_o=0, clk_en_o=0. A later start restarts with phase 0.
